thermostat_control: RTL and testbench
=====================================

THERMOSTAT_CONTROL -- requirements
Module: thermostat_control

Interface
REQ-001 Parameter SP_RESET, default 8'd44, reset setpoint in 0.5 C units (22.0 C).
REQ-002 Parameter HYST, default 8'd2, hysteresis band in 0.5 C units.
REQ-003 Parameter SP_MIN / SP_MAX, default 8'd20 / 8'd70, setpoint saturation limits.
REQ-004 Parameter STABLE_CYCLES, default 16'd1000, cycles an input temperature must hold before acceptance.
REQ-005 Parameter DEBOUNCE_CYCLES, default 20'd500000, cycles a button level must hold before acceptance.
REQ-006 Parameter MIN_DWELL, default 24'd1000000, minimum cycles spent in any control state.
REQ-007 CLK  input  1  system clock, all logic on rising edge.
REQ-008 RST_N  input  1  asynchronous active-low reset.
REQ-009 Temperature_8_Bit  input  8  unsigned sensor temperature, 0.5 C per LSB, from the I2C reader.
REQ-010 BTN_UP / BTN_DOWN  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-011 Setpoint  output  8  current setpoint, 0.5 C per LSB.
REQ-012 Temp_Q  output  8  last qualified temperature.
REQ-013 Temp_Valid  output  1  high once the first qualified temperature exists.
REQ-014 HEAT / COOL  output  1 each  actuator enables, registered, never both high.

Function
REQ-015 Temperature qualifier SHALL load Temp_Q when Temperature_8_Bit equals its previous-cycle value for STABLE_CYCLES consecutive cycles; any change restarts the count.
REQ-016 Temp_Valid SHALL rise on the first Temp_Q load and stay high until reset.
REQ-017 Each button SHALL pass a two-flop synchronizer, then a debounce counter; debounced level changes only after DEBOUNCE_CYCLES stable synchronized cycles.
REQ-018 A debounced rising edge of UP increments Setpoint by 1, DOWN decrements by 1, saturating at SP_MAX / SP_MIN.
REQ-019 Rising edges of UP and DOWN in the same cycle SHALL leave Setpoint unchanged.
REQ-020 Thresholds SHALL be computed 9-bit: LOW = max(Setpoint-HYST,0), HIGH = min(Setpoint+HYST,255); no wrap-around.
REQ-021 FSM states IDLE, HEATING, COOLING; a dwell counter clears on every state entry and saturates at MIN_DWELL.
REQ-022 IDLE->HEATING when Temp_Valid, dwell done, Temp_Q < LOW.
REQ-023 IDLE->COOLING when Temp_Valid, dwell done, Temp_Q > HIGH.
REQ-024 HEATING->IDLE when dwell done and Temp_Q >= Setpoint; COOLING->IDLE when dwell done and Temp_Q <= Setpoint.
REQ-025 HEATING<->COOLING direct transitions SHALL NOT occur; always via IDLE.
REQ-026 HEAT = (state==HEATING), COOL = (state==COOLING), registered, one cycle after the state change.
REQ-027 Setpoint changes SHALL take effect on thresholds the next cycle but never bypass dwell.

Reset
REQ-028 RST_N low SHALL immediately force: state IDLE, HEAT=0, COOL=0, Setpoint=SP_RESET, Temp_Q=0, Temp_Valid=0, all counters 0, debounced levels 0.
REQ-029 Reset asserted mid-HEATING or mid-COOLING SHALL drop the actuator output asynchronously, without waiting for CLK.
REQ-030 After RST_N release, no actuator SHALL assert before a new qualified temperature and a full MIN_DWELL.

Configuration
REQ-031 Macro THERMO_COOL_EN defined: COOLING state and COOL output operate per REQ-023/024.
REQ-032 Macro THERMO_COOL_EN undefined: COOLING state not built, COOL tied 0, Temp_Q > HIGH keeps IDLE.

Verification (bench parameters STABLE_CYCLES=4, DEBOUNCE_CYCLES=3, MIN_DWELL=8)
REQ-033 Reset, hold Temperature_8_Bit=30 for 4 cycles -> Temp_Valid=1, Temp_Q=30, HEAT=1 after dwell (30 < 42), COOL=0.
REQ-034 In HEATING, step temperature to 44 and hold -> HEAT=0 once qualified and dwell done; 43 keeps HEAT=1.
REQ-035 With THERMO_COOL_EN, temperature 47 from IDLE -> COOL=1; 46 -> stays IDLE; without macro 47 -> COOL=0.
REQ-036 Pulse BTN_UP 30 times (each held 5 cycles) -> Setpoint saturates 70; 2-cycle glitch -> no change; UP and DOWN together -> no change.
REQ-037 Temperature toggling 30/31 every 2 cycles -> Temp_Q never updates, Temp_Valid stays 0.
REQ-038 Assert RST_N low mid-HEATING between clock edges -> HEAT=0 immediately, Setpoint=44.

Source files
------------

// File: rtl/thermostat_control_if.sv
// ----------------------------------------------------------------------------
// thermostat_control_if
//   Bundles the sensor, pushbutton and actuator signals of the thermostat.
//
//   Signals:
//     Temperature_8_Bit  8  sensor temperature, 0.5 C per LSB
//     BTN_UP / BTN_DOWN  1  raw asynchronous pushbuttons, active-high
//     Setpoint           8  current setpoint, 0.5 C per LSB
//     Temp_Q             8  last qualified temperature
//     Temp_Valid         1  a qualified temperature exists
//     HEAT / COOL        1  registered actuator enables
//
//   Modports:
//     master : sensor / user-interface side (drives inputs, observes outputs)
//     slave  : thermostat_control
// ----------------------------------------------------------------------------
interface thermostat_control_if;
    logic [7:0] Temperature_8_Bit;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic [7:0] Setpoint;
    logic [7:0] Temp_Q;
    logic       Temp_Valid;
    logic       HEAT;
    logic       COOL;

    modport master (
        output Temperature_8_Bit, BTN_UP, BTN_DOWN,
        input  Setpoint, Temp_Q, Temp_Valid, HEAT, COOL
    );

    modport slave (
        input  Temperature_8_Bit, BTN_UP, BTN_DOWN,
        output Setpoint, Temp_Q, Temp_Valid, HEAT, COOL
    );
endinterface

// File: rtl/thermostat_control.sv
// ----------------------------------------------------------------------------
// thermostat_control
//   Hysteresis thermostat: qualifies a noisy sensor temperature, debounces
//   setpoint pushbuttons and drives HEAT / COOL through an IDLE / HEATING /
//   COOLING state machine with a minimum dwell time in every state.
//
//   Build option:
//     THERMO_COOL_EN  defined   -> COOLING state and COOL output are built
//                     undefined -> heating only, COOL tied low
//
//   Ports:
//     CLK    in  system clock, rising edge
//     RST_N  in  asynchronous active-low reset
//     bus    thermostat_control_if.slave (temperature, buttons, setpoint,
//            qualified temperature, actuator enables)
// ----------------------------------------------------------------------------
module thermostat_control #(
    parameter logic [7:0]  SP_RESET        = 8'd44,
    parameter logic [7:0]  HYST            = 8'd2,
    parameter logic [7:0]  SP_MIN          = 8'd20,
    parameter logic [7:0]  SP_MAX          = 8'd70,
    parameter logic [15:0] STABLE_CYCLES   = 16'd1000,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] MIN_DWELL       = 24'd1000000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    thermostat_control_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEATING = 2'd1;
`ifdef THERMO_COOL_EN
    localparam logic [1:0] COOLING = 2'd2;
`endif

    // ------------------------------------------------------------------
    // Temperature qualifier: a reading is accepted only after it has been
    // identical to its previous-cycle value STABLE_CYCLES times in a row.
    // ------------------------------------------------------------------
    logic [7:0]  temp_prev;
    logic [7:0]  temp_q;
    logic        temp_valid;
    logic [15:0] stable_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            temp_prev  <= '0;
            temp_q     <= '0;
            temp_valid <= 1'b0;
            stable_cnt <= '0;
        end else begin
            temp_prev <= bus.Temperature_8_Bit;
            if (bus.Temperature_8_Bit != temp_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_CYCLES) begin
                // Count saturates so a held reading loads exactly once.
                stable_cnt <= stable_cnt + 16'd1;
                if (stable_cnt == STABLE_CYCLES - 16'd1) begin
                    temp_q     <= bus.Temperature_8_Bit;
                    temp_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Buttons: two-flop synchronizer, then a level debouncer. Index 0 is
    // UP, index 1 is DOWN.
    // ------------------------------------------------------------------
    logic [1:0]  btn_raw;
    logic [1:0]  sync_1;
    logic [1:0]  sync_2;
    logic [1:0]  db_level;
    logic [1:0]  db_level_d;
    logic [1:0]  btn_rise;
    logic [19:0] db_cnt [2];

    assign btn_raw  = {bus.BTN_DOWN, bus.BTN_UP};
    assign btn_rise = db_level & ~db_level_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_1     <= '0;
            sync_2     <= '0;
            db_level   <= '0;
            db_level_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1     <= btn_raw;
            sync_2     <= sync_1;
            db_level_d <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    db_level[i] <= sync_2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Setpoint: saturating up/down; simultaneous edges cancel.
    // ------------------------------------------------------------------
    logic [7:0] setpoint;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            setpoint <= SP_RESET;
        end else if (btn_rise[0] && !btn_rise[1] && setpoint < SP_MAX) begin
            setpoint <= setpoint + 8'd1;
        end else if (btn_rise[1] && !btn_rise[0] && setpoint > SP_MIN) begin
            setpoint <= setpoint - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Thresholds in 9 bits, clamped to 0..255 instead of wrapping.
    // ------------------------------------------------------------------
    logic [8:0] sp_ext;
    logic [8:0] temp_ext;
    logic [8:0] low_thr;

    assign sp_ext   = {1'b0, setpoint};
    assign temp_ext = {1'b0, temp_q};
    assign low_thr  = (setpoint >= HYST) ? (sp_ext - {1'b0, HYST}) : 9'd0;

`ifdef THERMO_COOL_EN
    logic [8:0] high_sum;
    logic [8:0] high_thr;

    assign high_sum = sp_ext + {1'b0, HYST};
    assign high_thr = (high_sum > 9'd255) ? 9'd255 : high_sum;
`endif

    // ------------------------------------------------------------------
    // Control FSM with dwell counter. HEATING and COOLING only ever exit
    // to IDLE, so a direct heat/cool swap cannot happen.
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [23:0] dwell_cnt;
    logic        dwell_done;
    logic        heat_q;

    assign dwell_done = (dwell_cnt == MIN_DWELL);

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (temp_valid && dwell_done) begin
                    if (temp_ext < low_thr) begin
                        state_next = HEATING;
                    end
`ifdef THERMO_COOL_EN
                    else if (temp_ext > high_thr) begin
                        state_next = COOLING;
                    end
`endif
                end
            end
            HEATING: begin
                if (dwell_done && temp_q >= setpoint) begin
                    state_next = IDLE;
                end
            end
`ifdef THERMO_COOL_EN
            COOLING: begin
                if (dwell_done && temp_q <= setpoint) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Actuators come from the registered state, so they follow a state
    // change by one cycle; reset clears them asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            heat_q    <= 1'b0;
        end else begin
            state  <= state_next;
            heat_q <= (state == HEATING);
            if (state_next != state) begin
                dwell_cnt <= '0;
            end else if (!dwell_done) begin
                dwell_cnt <= dwell_cnt + 24'd1;
            end
        end
    end

`ifdef THERMO_COOL_EN
    logic cool_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cool_q <= 1'b0;
        end else begin
            cool_q <= (state == COOLING);
        end
    end

    assign bus.COOL = cool_q;
`else
    assign bus.COOL = 1'b0;
`endif

    assign bus.HEAT       = heat_q;
    assign bus.Setpoint   = setpoint;
    assign bus.Temp_Q     = temp_q;
    assign bus.Temp_Valid = temp_valid;

endmodule

// File: tb/tb_thermostat_control.sv
// ----------------------------------------------------------------------------
// tb_thermostat_control
//   Directed bench for thermostat_control with short qualifier, debounce and
//   dwell parameters. Expected COOL behaviour follows THERMO_COOL_EN.
// ----------------------------------------------------------------------------
module tb_thermostat_control;

    logic CLK;
    logic RST_N;

    thermostat_control_if thermo_if ();

    thermostat_control #(
        .SP_RESET        (8'd44),
        .HYST            (8'd2),
        .SP_MIN          (8'd20),
        .SP_MAX          (8'd70),
        .STABLE_CYCLES   (16'd4),
        .DEBOUNCE_CYCLES (20'd3),
        .MIN_DWELL       (24'd8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (thermo_if.slave)
    );

`ifdef THERMO_COOL_EN
    localparam logic COOL_BUILT = 1'b1;
`else
    localparam logic COOL_BUILT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic both_high_seen = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (thermo_if.HEAT && thermo_if.COOL) both_high_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Hold the buttons for `hold` cycles, then release long enough for the
    // debouncer to settle low again.
    task automatic press(input logic up, input logic down, input int hold);
        thermo_if.BTN_UP   = up;
        thermo_if.BTN_DOWN = down;
        cycles(hold);
        thermo_if.BTN_UP   = 1'b0;
        thermo_if.BTN_DOWN = 1'b0;
        cycles(8);
    endtask

    initial begin
        RST_N                       = 1'b0;
        thermo_if.Temperature_8_Bit = 8'd30;
        thermo_if.BTN_UP            = 1'b0;
        thermo_if.BTN_DOWN          = 1'b0;
        cycles(3);

        check("rst_heat",     32'(thermo_if.HEAT),       32'd0);
        check("rst_cool",     32'(thermo_if.COOL),       32'd0);
        check("rst_setpoint", 32'(thermo_if.Setpoint),   32'd44);
        check("rst_temp_q",   32'(thermo_if.Temp_Q),     32'd0);
        check("rst_valid",    32'(thermo_if.Temp_Valid), 32'd0);

        // Release on a falling edge; 30 held from here qualifies on the
        // fifth rising edge and heating starts after the 8-cycle dwell.
        RST_N = 1'b1;
        cycles(4);
        check("qual_not_yet", 32'(thermo_if.Temp_Valid), 32'd0);
        cycles(2);
        check("qual_valid",   32'(thermo_if.Temp_Valid), 32'd1);
        check("qual_temp_q",  32'(thermo_if.Temp_Q),     32'd30);
        check("dwell_hold",   32'(thermo_if.HEAT),       32'd0);
        cycles(3);
        check("heat_lag",     32'(thermo_if.HEAT),       32'd0);
        cycles(1);
        check("heat_on",      32'(thermo_if.HEAT),       32'd1);
        check("heat_no_cool", 32'(thermo_if.COOL),       32'd0);

        // Just below setpoint keeps heating; reaching it stops.
        thermo_if.Temperature_8_Bit = 8'd43;
        cycles(20);
        check("t43_temp_q", 32'(thermo_if.Temp_Q), 32'd43);
        check("t43_heat",   32'(thermo_if.HEAT),   32'd1);
        thermo_if.Temperature_8_Bit = 8'd44;
        cycles(20);
        check("t44_temp_q", 32'(thermo_if.Temp_Q), 32'd44);
        check("t44_heat",   32'(thermo_if.HEAT),   32'd0);

        // HIGH = 46: equal stays idle, one above cools (when built).
        thermo_if.Temperature_8_Bit = 8'd46;
        cycles(20);
        check("t46_cool", 32'(thermo_if.COOL), 32'd0);
        check("t46_heat", 32'(thermo_if.HEAT), 32'd0);
        thermo_if.Temperature_8_Bit = 8'd47;
        cycles(20);
        check("t47_cool", 32'(thermo_if.COOL), 32'(COOL_BUILT));
        check("t47_heat", 32'(thermo_if.HEAT), 32'd0);
        thermo_if.Temperature_8_Bit = 8'd44;
        cycles(25);
        check("cool_exit", 32'(thermo_if.COOL), 32'd0);

        // LOW = 42: equal stays idle, one below heats.
        thermo_if.Temperature_8_Bit = 8'd42;
        cycles(25);
        check("t42_heat", 32'(thermo_if.HEAT), 32'd0);
        thermo_if.Temperature_8_Bit = 8'd41;
        cycles(25);
        check("t41_heat", 32'(thermo_if.HEAT), 32'd1);

        // Setpoint buttons.
        press(1'b0, 1'b1, 5);
        check("sp_down",   32'(thermo_if.Setpoint), 32'd43);
        press(1'b1, 1'b1, 5);
        check("sp_both",   32'(thermo_if.Setpoint), 32'd43);
        press(1'b1, 1'b0, 2);
        check("sp_glitch", 32'(thermo_if.Setpoint), 32'd43);
        press(1'b1, 1'b0, 5);
        check("sp_up",     32'(thermo_if.Setpoint), 32'd44);
        for (int i = 0; i < 29; i++) press(1'b1, 1'b0, 5);
        check("sp_sat_max", 32'(thermo_if.Setpoint), 32'd70);
        check("heat_at_70", 32'(thermo_if.HEAT),     32'd1);

        // Asynchronous reset between clock edges while heating.
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_heat",     32'(thermo_if.HEAT),       32'd0);
        check("async_cool",     32'(thermo_if.COOL),       32'd0);
        check("async_setpoint", 32'(thermo_if.Setpoint),   32'd44);
        check("async_valid",    32'(thermo_if.Temp_Valid), 32'd0);
        check("async_temp_q",   32'(thermo_if.Temp_Q),     32'd0);

        // A reading that toggles every 2 cycles never qualifies.
        thermo_if.Temperature_8_Bit = 8'd30;
        cycles(2);
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycles(2);
            thermo_if.Temperature_8_Bit = (thermo_if.Temperature_8_Bit == 8'd30)
                                          ? 8'd31 : 8'd30;
        end
        check("toggle_valid",  32'(thermo_if.Temp_Valid), 32'd0);
        check("toggle_temp_q", 32'(thermo_if.Temp_Q),     32'd0);
        check("toggle_heat",   32'(thermo_if.HEAT),       32'd0);

        check("never_both_high", 32'(both_high_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
